// File: rtl/fp_pkg.sv
// ============================================================================
//  Module   : fp_pkg
//  Purpose  : Single-precision constants and operand class encoding shared
//             by the rounding stage and its combinational core.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fp_pkg;

  localparam int          BIAS   = 127;
  localparam int          EXP_W  = 8;
  localparam int          MAN_W  = 23;
  localparam int          PROD_W = 48;

  localparam logic [31:0] QNAN   = 32'h7FC0_0000;
  localparam logic [31:0] P_INF  = 32'h7F80_0000;
  localparam logic [31:0] N_INF  = 32'hFF80_0000;
  localparam logic [31:0] ZERO   = 32'h0000_0000;

  typedef enum logic [1:0] {
    FP_NORMAL = 2'b00,
    FP_ZERO   = 2'b01,
    FP_INF    = 2'b10,
    FP_NAN    = 2'b11
  } fp_class_t;

endpackage : fp_pkg

`default_nettype wire

// File: rtl/fp_round_core.sv
// ============================================================================
//  Module   : fp_round_core
//  Purpose  : Combinational round, carry-propagate and IEEE-754 pack of a
//             normalized significand. FP_ROUND_RNE_EN selects round-to-
//             nearest-even; otherwise the significand is truncated.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_round_core
  import fp_pkg::*;
(
  input  logic              sign_i,
  input  fp_class_t         cls_i,
  input  logic [MAN_W-1:0]  mant_i,
  input  logic              guard_i,
  input  logic              sticky_i,
  input  logic signed [9:0] exp_i,
  output logic [31:0]       result_o,
  output logic              overflow_o,
  output logic              underflow_o,
  output logic              inexact_o
);

  logic              inc;
  logic [MAN_W:0]    mant_inc;
  logic signed [10:0] exp_r;

`ifdef FP_ROUND_RNE_EN
  assign inc = guard_i & (sticky_i | mant_i[0]);
`else
  assign inc = 1'b0;
`endif

  // A carry out of the 23-bit field means the significand wrapped to 1.0.
  assign mant_inc = {1'b0, mant_i} + {{MAN_W{1'b0}}, inc};
  assign exp_r    = $signed({exp_i[9], exp_i}) + $signed({10'd0, mant_inc[MAN_W]});

  always_comb begin
    result_o    = ZERO;
    overflow_o  = 1'b0;
    underflow_o = 1'b0;
    inexact_o   = 1'b0;
    unique case (cls_i)
      FP_ZERO: result_o = {sign_i, 31'h0};
      FP_INF:  result_o = sign_i ? N_INF : P_INF;
      FP_NAN:  result_o = QNAN;
      default: begin
        if (exp_r >= 11'sd255) begin
          result_o   = sign_i ? N_INF : P_INF;
          overflow_o = 1'b1;
          inexact_o  = 1'b1;
        end else if (exp_r <= 11'sd0) begin
          result_o    = {sign_i, 31'h0};
          underflow_o = 1'b1;
          inexact_o   = 1'b1;
        end else begin
          result_o  = {sign_i, exp_r[EXP_W-1:0], mant_inc[MAN_W-1:0]};
          inexact_o = guard_i | sticky_i;
        end
      end
    endcase
  end

endmodule : fp_round_core

`default_nettype wire

// File: rtl/fp_round_stage.sv
// ============================================================================
//  Module   : fp_round_stage
//  Purpose  : Two-stage normalize / round / pack pipeline for a single-
//             precision multiplier, with valid/ready handshake per stage.
//             Rounding mode set by FP_ROUND_RNE_EN (see fp_round_core).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_round_stage
  import fp_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [8:0]        in_exp_sum,
  input  logic [PROD_W-1:0] in_prod,
  input  logic [1:0]        in_class,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_result,
  output logic              out_overflow,
  output logic              out_underflow,
  output logic              out_inexact
);

  if (LATENCY != 2) begin : g_latency_check
    $error("fp_round_stage: LATENCY must be 2");
  end

  logic              v1_q, v2_q;
  logic              ready1, ready2;

  logic              sign1_q;
  fp_class_t         cls1_q;
  logic [MAN_W-1:0]  mant1_q,   mant1_d;
  logic              guard1_q,  guard1_d;
  logic              sticky1_q, sticky1_d;
  logic signed [9:0] exp1_q,    exp1_d;
  logic [9:0]        exp_ext;

  logic [31:0]       result_q,  result_d;
  logic              ovf_q,     ovf_d;
  logic              unf_q,     unf_d;
  logic              inx_q,     inx_d;

  assign ready2   = !v2_q | out_ready;
  assign ready1   = !v1_q | ready2;
  assign in_ready = ready1;

  assign exp_ext  = {1'b0, in_exp_sum};

  // Products lie in [1,4); a set MSB means one extra binade.
  always_comb begin
    mant1_d   = in_prod[46:24];
    guard1_d  = in_prod[23];
    sticky1_d = |in_prod[22:0];
    exp1_d    = exp_ext - 10'(BIAS - 1);
    if (!in_prod[PROD_W-1]) begin
      mant1_d   = in_prod[45:23];
      guard1_d  = in_prod[22];
      sticky1_d = |in_prod[21:0];
      exp1_d    = exp_ext - 10'(BIAS);
    end
  end

  fp_round_core u_core (
    .sign_i      (sign1_q),
    .cls_i       (cls1_q),
    .mant_i      (mant1_q),
    .guard_i     (guard1_q),
    .sticky_i    (sticky1_q),
    .exp_i       (exp1_q),
    .result_o    (result_d),
    .overflow_o  (ovf_d),
    .underflow_o (unf_d),
    .inexact_o   (inx_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      sign1_q   <= 1'b0;
      cls1_q    <= FP_NORMAL;
      mant1_q   <= '0;
      guard1_q  <= 1'b0;
      sticky1_q <= 1'b0;
      exp1_q    <= '0;
      result_q  <= ZERO;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      inx_q     <= 1'b0;
    end else begin
      if (ready1) begin
        v1_q <= in_valid;
        if (in_valid) begin
          sign1_q   <= in_sign;
          cls1_q    <= fp_class_t'(in_class);
          mant1_q   <= mant1_d;
          guard1_q  <= guard1_d;
          sticky1_q <= sticky1_d;
          exp1_q    <= exp1_d;
        end
      end
      // Output register only loads on a stage-2 transfer, so a stalled
      // result holds steady.
      if (ready2) begin
        v2_q <= v1_q;
        if (v1_q) begin
          result_q <= result_d;
          ovf_q    <= ovf_d;
          unf_q    <= unf_d;
          inx_q    <= inx_d;
        end
      end
    end
  end

  assign out_valid     = v2_q;
  assign out_result    = result_q;
  assign out_overflow  = ovf_q;
  assign out_underflow = unf_q;
  assign out_inexact   = inx_q;

endmodule : fp_round_stage

`default_nettype wire

// File: doc/fp_round_stage.md
FP_ROUND_STAGE -- requirements
Module: fp_round_stage

Interface
REQ-001 Parameter LATENCY, default 2, fixed pipeline depth in cycles; the only legal value is 2.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 in_valid  in  1  upstream multiplier-core product valid.
REQ-005 in_ready  out  1  stage can accept an input this cycle.
REQ-006 in_sign  in  1  product sign (s1 XOR s2).
REQ-007 in_exp_sum  in  9  raw biased exponent sum e1+e2.
REQ-008 in_prod  in  48  raw unnormalized mantissa product {1,m1}*{1,m2}.
REQ-009 in_class  in  2  00 normal, 01 zero, 10 infinity, 11 NaN.
REQ-010 out_valid  out  1  result valid.
REQ-011 out_ready  in  1  downstream accepts the result.
REQ-012 out_result  out  32  IEEE-754 single-precision result.
REQ-013 out_overflow, out_underflow, out_inexact  out  1 each  sticky-free per-result flags.

Function
REQ-014 Stage 1 shall normalize: if in_prod[47]=1, mant=prod[46:24], guard=prod[23], sticky=OR(prod[22:0]), exp=exp_sum-126; otherwise mant=prod[45:23], guard=prod[22], sticky=OR(prod[21:0]), exp=exp_sum-127.
REQ-015 The stage 1 exponent shall be held as a 10-bit signed value, so that results below 1 and at or above 255 are both representable.
REQ-016 Stage 2 shall round, add the carry from rounding, and pack the result.
REQ-017 When mant is all ones and rounding increments it, mant shall become 0 and exp shall increase by 1.
REQ-018 After rounding, exp>=255 shall produce {sign,8'hFF,23'h0} with out_overflow=1 and out_inexact=1.
REQ-019 After rounding, exp<=0 shall flush to {sign,31'h0} with out_underflow=1 and out_inexact=1; no subnormals are produced.
REQ-020 For a normal result, out_inexact shall equal guard OR sticky.
REQ-021 in_class=01 shall give {in_sign,31'h0}.
REQ-022 in_class=10 shall give {in_sign,8'hFF,23'h0}.
REQ-023 in_class=11 shall give 32'h7FC00000.
REQ-024 For any special class (REQ-021 to REQ-023), all flags shall be 0 and in_prod/in_exp_sum shall be ignored.
REQ-025 Latency shall be exactly 2 cycles from input acceptance to out_valid when there is no backpressure; throughput shall be 1 result per cycle.
REQ-026 Each stage register shall use a valid bit: ready2 = !v2 | out_ready; ready1 = !v1 | ready2; in_ready = ready1.
REQ-027 A transfer shall occur only when valid and ready are both high on the same edge.
REQ-028 While out_valid=1 and out_ready=0, out_result and all flags shall hold stable.
REQ-029 Results shall leave the stage in acceptance order, with none lost or duplicated under any out_ready pattern.
REQ-030 A simultaneous accept at stage 1 and drain at stage 2 in the same cycle shall be lossless.

Reset
REQ-031 While rst=1, at the clock edge v1, v2, out_valid and all flags shall be 0 and out_result shall be 32'h0.
REQ-032 Reset asserted mid-operation shall discard all in-flight data.
REQ-033 in_ready shall be 1 in the first cycle after rst deasserts.

Configuration
REQ-034 With FP_ROUND_RNE_EN defined, stage 2 shall round to nearest, ties to even: increment when guard AND (sticky OR mant[0]).
REQ-035 Without FP_ROUND_RNE_EN, stage 2 shall truncate: never increment; out_inexact is still reported.

Structure
REQ-036 Package fp_pkg shall hold the constants BIAS=127, EXP_W=8, MAN_W=23, PROD_W=48, QNAN=32'h7FC00000, P_INF, N_INF and ZERO, plus the fp_class_t encoding.
REQ-037 The rounding/packing logic shall be one combinational sub-module, fp_round_core; the pipeline registers and handshake shall stay in fp_round_stage.

Verification
REQ-038 Normal case: exp_sum=254, prod=48'h900000000000, sign=0 -> out_result=32'h40100000 two cycles later, flags all 0.
REQ-039 Rounding case: exp_sum=254, prod=48'h400000C00000 -> with RNE 32'h3F800002, without RNE 32'h3F800001; out_inexact=1 in both builds.
REQ-040 Mantissa carry case: exp_sum=254, prod=48'h7FFFFFC00000 -> RNE 32'h40000000; truncate 32'h3FFFFFFF.
REQ-041 Overflow case: exp_sum=400, prod=48'h800000000000, sign=0 -> 32'h7F800000 with overflow=1.
REQ-042 Underflow case: exp_sum=100, prod=48'h400000000000, sign=1 -> 32'h80000000 with underflow=1.
REQ-043 Backpressure case: send 4 back-to-back inputs with out_ready=0 for 4 cycles -> in_ready falls after 2 accepts, outputs stay stable, all 4 results emerge in order; rst pulsed mid-stream -> out_valid=0 next cycle.
